// File: rtl/johnson_phase_decoder_if.sv
// Interface bundling the Johnson phase decoder data path.
//   master : drives jc_in (raw Johnson state word) and clr_err (error-count clear),
//            observes the decoded phase, qualification and error outputs.
//   slave  : the decoder side of the same signals.
interface johnson_phase_decoder_if #(
    parameter int N     = 4,
    parameter int ERR_W = 8
);
    localparam int IDX_W = $clog2(2 * N);

    logic [N-1:0]     jc_in;
    logic             clr_err;
    logic [2*N-1:0]   phase;
    logic [IDX_W-1:0] phase_idx;
    logic             phase_valid;
    logic             locked;
    logic             illegal;
    logic             resync_req;
    logic [ERR_W-1:0] err_count;

    modport master (
        output jc_in, clr_err,
        input  phase, phase_idx, phase_valid, locked, illegal, resync_req, err_count
    );

    modport slave (
        input  jc_in, clr_err,
        output phase, phase_idx, phase_valid, locked, illegal, resync_req, err_count
    );
endinterface

// File: rtl/johnson_phase_decoder.sv
// Decodes the raw state word of an N-stage Johnson counter into a one-hot phase
// and a binary phase index, checks code legality and step sequencing, and
// qualifies the phase with a HUNT/LOCKED/FAULT lock machine. Loss of lock raises
// resync_req for HOLDOFF cycles; errors accumulate in a saturating counter.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-low reset
//   bus    slave side of johnson_phase_decoder_if (jc_in, clr_err in;
//          phase, phase_idx, phase_valid, locked, illegal, resync_req, err_count out)
// Latency jc_in -> outputs is two clock edges; all outputs are registered.
module johnson_phase_decoder #(
    parameter int N        = 4,
    parameter int LOCK_CNT = 4,
    parameter int HOLDOFF  = 2,
    parameter int ERR_W    = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    johnson_phase_decoder_if.slave bus
);
    localparam int P      = 2 * N;
    localparam int IDX_W  = $clog2(P);
    localparam int RUN_W  = $clog2(LOCK_CNT + 1);
    localparam int HOLD_W = $clog2(HOLDOFF + 1);

    typedef enum logic [1:0] {HUNT, LOCKED, FAULT} state_t;

    state_t            state, state_n;
    logic [N-1:0]      jc_q;
    logic [RUN_W-1:0]  run, run_n;
    logic [HOLD_W-1:0] holdoff, hold_n;
    logic [IDX_W-1:0]  prev_idx, prev_idx_n, prev_succ;
    logic              prev_vld, prev_vld_n;
    logic [IDX_W-1:0]  idx;
    logic              legal, step_good, step_stall, step_bad, err_evt;
    int unsigned       pop, trans;

    logic [P-1:0]      phase_q, phase_n;
    logic [IDX_W-1:0]  phase_idx_q, phase_idx_n;
    logic              phase_valid_q, locked_q, illegal_q, resync_q;
    logic [ERR_W-1:0]  err_q, err_n;

    // A Johnson code is monotonic across its bits: at most one adjacent-bit change.
    always_comb begin
        pop   = 0;
        trans = 0;
        for (int unsigned i = 0; i < N; i++) begin
            pop += 32'(jc_q[i]);
        end
        for (int unsigned i = 1; i < N; i++) begin
            if (jc_q[i] != jc_q[i-1]) trans++;
        end
        legal = (trans <= 1);
        idx   = jc_q[N-1] ? IDX_W'(P - int'(pop)) : IDX_W'(pop);
    end

    always_comb begin
        prev_succ  = (prev_idx == IDX_W'(P - 1)) ? '0 : prev_idx + IDX_W'(1);
        step_good  = prev_vld && legal && (idx == prev_succ);
        step_stall = prev_vld && legal && (idx == prev_idx);
        step_bad   = prev_vld && legal && !step_good && !step_stall;
    end

    always_comb begin
        state_n    = state;
        run_n      = run;
        hold_n     = holdoff;
        prev_idx_n = legal ? idx : prev_idx;
        prev_vld_n = legal;
        err_evt    = 1'b0;
        case (state)
            HUNT: begin
                if (!legal) begin
                    run_n   = '0;
                    err_evt = 1'b1;
                end else if (!prev_vld) begin
                    run_n = '0;
                end else if (step_good) begin
                    if (int'(run) + 1 >= LOCK_CNT) begin
                        state_n = LOCKED;
                        run_n   = '0;
                    end else begin
                        run_n = run + RUN_W'(1);
                    end
                end else if (!step_stall) begin
                    run_n = '0;
                end
            end
            LOCKED: begin
                if (!legal || step_bad) begin
                    state_n = FAULT;
                    hold_n  = HOLD_W'(HOLDOFF);
                    err_evt = 1'b1;
                end
            end
            FAULT: begin
                // Input is ignored here; forcing prev_vld low makes the first
                // legal code after returning to HUNT a fresh starting point.
                prev_vld_n = 1'b0;
                hold_n     = holdoff - HOLD_W'(1);
                if (holdoff <= HOLD_W'(1)) begin
                    state_n = HUNT;
                    run_n   = '0;
                end
            end
            default: state_n = HUNT;
        endcase
    end

    always_comb begin
        phase_n = '0;
        if (legal) phase_n[idx] = 1'b1;
        phase_idx_n = legal ? idx : phase_idx_q;
        if (bus.clr_err) begin
            err_n = err_evt ? ERR_W'(1) : '0;
        end else if (err_evt && (err_q != '1)) begin
            err_n = err_q + ERR_W'(1);
        end else begin
            err_n = err_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            jc_q          <= '0;
            state         <= HUNT;
            run           <= '0;
            holdoff       <= '0;
            prev_idx      <= '0;
            prev_vld      <= 1'b0;
            phase_q       <= '0;
            phase_idx_q   <= '0;
            phase_valid_q <= 1'b0;
            locked_q      <= 1'b0;
            illegal_q     <= 1'b0;
            resync_q      <= 1'b0;
            err_q         <= '0;
        end else begin
            jc_q          <= bus.jc_in;
            state         <= state_n;
            run           <= run_n;
            holdoff       <= hold_n;
            prev_idx      <= prev_idx_n;
            prev_vld      <= prev_vld_n;
            phase_q       <= phase_n;
            phase_idx_q   <= phase_idx_n;
            phase_valid_q <= (state_n == LOCKED) && legal;
            locked_q      <= (state_n == LOCKED);
            illegal_q     <= !legal;
            resync_q      <= (state_n == FAULT);
            err_q         <= err_n;
        end
    end

    assign bus.phase       = phase_q;
    assign bus.phase_idx   = phase_idx_q;
    assign bus.phase_valid = phase_valid_q;
    assign bus.locked      = locked_q;
    assign bus.illegal     = illegal_q;
    assign bus.resync_req  = resync_q;
    assign bus.err_count   = err_q;
endmodule
